// File: rtl/adder_chk_pkg.sv
// Shared definitions for the adder stimulus/check engine: FSM encoding and error-counter sizing.
package adder_chk_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int ERR_W = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = 8'd255;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == ERR_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/adder_chk_ref.sv
// Golden (N+1)-bit sum of the registered operands; purely combinational, no handshake.
module adder_chk_ref #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c,
    output logic [N:0]   sum_exp
);

    assign sum_exp = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};

endmodule

// File: rtl/adder_stim_check.sv
// Exhaustive-style stimulus/check engine for an external adder: SETTLE+2 cycles per vector, start ignored while busy.
// Optional first-failure capture (fail_vec/fail_valid) when ADDER_CHK_FIRSTFAIL_EN is defined.
module adder_stim_check
    import adder_chk_pkg::*;
#(
    parameter int N       = 8,
    parameter int NUM_VEC = 16,
    parameter int SETTLE  = 1,
    parameter int STRIDE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [N-1:0]     in1,
    output logic [N-1:0]     in2,
    output logic             cin,
    input  logic [N-1:0]     sum,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count
`ifdef ADDER_CHK_FIRSTFAIL_EN
    ,
    output logic [2*N:0]     fail_vec,
    output logic             fail_valid
`endif
);

    localparam int IW = 2*N + 1;
    localparam logic [IW-1:0] LAST_VEC = IW'(NUM_VEC - 1);
    localparam logic [IW-1:0] STEP     = IW'(STRIDE);
    localparam logic [3:0]    WAIT_END = 4'(SETTLE - 1);

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    vcnt_q, vcnt_d;
    logic [IW-1:0]    ops_q, ops_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             pass_q, pass_d;
    logic [N:0]       exp_sum;
    logic             mismatch;
`ifdef ADDER_CHK_FIRSTFAIL_EN
    logic [IW-1:0]    fvec_q, fvec_d;
    logic             fval_q, fval_d;
`endif

    adder_chk_ref #(.N(N)) u_ref (
        .a       (ops_q[N-1:0]),
        .b       (ops_q[2*N-1:N]),
        .c       (ops_q[2*N]),
        .sum_exp (exp_sum)
    );

    assign mismatch = ({cout, sum} != exp_sum);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        vcnt_d  = vcnt_q;
        ops_d   = ops_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        pass_d  = pass_q;
`ifdef ADDER_CHK_FIRSTFAIL_EN
        fvec_d  = fvec_q;
        fval_d  = fval_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    vcnt_d  = '0;
                    err_d   = '0;
                    pass_d  = 1'b0;
`ifdef ADDER_CHK_FIRSTFAIL_EN
                    fvec_d  = '0;
                    fval_d  = 1'b0;
`endif
                end
            end
            LOAD: begin
                ops_d   = idx_q;
                wcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (wcnt_q == WAIT_END) begin
                    state_d = CHECK;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    err_d = sat_inc(err_q);
`ifdef ADDER_CHK_FIRSTFAIL_EN
                    if (!fval_q) begin
                        fvec_d = ops_q;
                        fval_d = 1'b1;
                    end
`endif
                end
                // The vector counter, not idx, terminates the run: idx may wrap.
                if (vcnt_q == LAST_VEC) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + STEP;
                    vcnt_d  = vcnt_q + 1'b1;
                    state_d = LOAD;
                end
            end
            DONE: begin
                pass_d  = (err_q == '0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            vcnt_q  <= '0;
            ops_q   <= '0;
            wcnt_q  <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
`ifdef ADDER_CHK_FIRSTFAIL_EN
            fvec_q  <= '0;
            fval_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vcnt_q  <= vcnt_d;
            ops_q   <= ops_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
`ifdef ADDER_CHK_FIRSTFAIL_EN
            fvec_q  <= fvec_d;
            fval_q  <= fval_d;
`endif
        end
    end

    assign in1       = ops_q[N-1:0];
    assign in2       = ops_q[2*N-1:N];
    assign cin       = ops_q[2*N];
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign err_count = err_q;
`ifdef ADDER_CHK_FIRSTFAIL_EN
    assign fail_vec   = fvec_q;
    assign fail_valid = fval_q;
`endif

endmodule

// File: tb/tb_adder_stim_check.sv
// Bench for adder_stim_check: two configurations driving a behavioural adder with selectable faults.
module tb_adder_stim_check;

    typedef struct {
        int d;
        int t0;
        int err;
        int first;
    } run_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_w [2];
    logic [7:0] in1_w   [2];
    logic [7:0] in2_w   [2];
    logic       cin_w   [2];
    logic [7:0] sum_w   [2];
    logic       cout_w  [2];
    logic       busy_w  [2];
    logic       done_w  [2];
    logic       pass_w  [2];
    logic [7:0] err_w   [2];
`ifdef ADDER_CHK_FIRSTFAIL_EN
    logic [16:0] fv_w   [2];
    logic        fval_w [2];
`endif

    int   fault [2];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    run_t exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Per-instance configuration: 0 = defaults, 1 = long strided run.
    function automatic int p_s(input int d);   return (d == 0) ? 1  : 2;   endfunction
    function automatic int p_nv(input int d);  return (d == 0) ? 16 : 300; endfunction
    function automatic int p_st(input int d);  return (d == 0) ? 1  : 3;   endfunction

    function automatic int idx_at(input int d, input int k);
        return (k * p_st(d)) % (1 << 17);
    endfunction

    // Adder under test: fm 0 = correct, 1 = sum[0] inverted, 2 = cout inverted when in1 == in2.
    function automatic logic [8:0] add_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic c, input int fm);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b} + {8'd0, c};
        if (fm == 1) s[0] = ~s[0];
        else if (fm == 2 && a == b) s[8] = ~s[8];
        return s;
    endfunction

    assign {cout_w[0], sum_w[0]} = add_model(in1_w[0], in2_w[0], cin_w[0], fault[0]);
    assign {cout_w[1], sum_w[1]} = add_model(in1_w[1], in2_w[1], cin_w[1], fault[1]);

    adder_stim_check #(.N(8), .NUM_VEC(16), .SETTLE(1), .STRIDE(1)) dut0 (
        .clk(clk), .rst(rst), .start(start_w[0]),
        .in1(in1_w[0]), .in2(in2_w[0]), .cin(cin_w[0]),
        .sum(sum_w[0]), .cout(cout_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
`ifdef ADDER_CHK_FIRSTFAIL_EN
        .fail_vec(fv_w[0]), .fail_valid(fval_w[0]),
`endif
        .err_count(err_w[0])
    );

    adder_stim_check #(.N(8), .NUM_VEC(300), .SETTLE(2), .STRIDE(3)) dut1 (
        .clk(clk), .rst(rst), .start(start_w[1]),
        .in1(in1_w[1]), .in2(in2_w[1]), .cin(cin_w[1]),
        .sum(sum_w[1]), .cout(cout_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
`ifdef ADDER_CHK_FIRSTFAIL_EN
        .fail_vec(fv_w[1]), .fail_valid(fval_w[1]),
`endif
        .err_count(err_w[1])
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: count faulty vectors by enumerating the index sequence.
    function automatic run_t make_run(input int d, input int t0, input int fm);
        run_t r;
        int   cnt;
        cnt = 0;
        r.first = -1;
        for (int k = 0; k < p_nv(d); k++) begin
            int idx = idx_at(d, k);
            int a   = idx & 255;
            int b   = (idx >> 8) & 255;
            if (fm == 1 || (fm == 2 && a == b)) begin
                cnt++;
                if (r.first < 0) r.first = idx;
            end
        end
        r.d   = d;
        r.t0  = t0;
        r.err = (cnt > 255) ? 255 : cnt;
        return r;
    endfunction

    // Monitor: checks operands and busy every cycle of the active run, results on done.
    logic pend = 1'b0;
    int   pend_d, pend_err;
    always @(negedge clk) begin
        run_t r;
        int   per, last, rel, k;
        if (pend) begin
            chk("pass_after_done", pass_w[pend_d], (pend_err == 0) ? 1 : 0);
            chk("err_hold", err_w[pend_d], pend_err);
            chk("busy_low_after_done", busy_w[pend_d], 0);
            pend = 1'b0;
        end
        if (exp_q.size() > 0) begin
            r    = exp_q[0];
            per  = p_s(r.d) + 2;
            last = per * p_nv(r.d);
            rel  = cyc - r.t0 - 1;
            if (rel >= 0 && rel <= last) chk("busy_in_run", busy_w[r.d], 1);
            if (rel >= 1 && rel <= last) begin
                k = (rel - 1) / per;
                chk("operands", {cin_w[r.d], in2_w[r.d], in1_w[r.d]}, idx_at(r.d, k));
            end
            if (rel == last) begin
                chk("done_at_edge", done_w[r.d], 1);
                chk("err_count", err_w[r.d], r.err);
`ifdef ADDER_CHK_FIRSTFAIL_EN
                chk("fail_valid", fval_w[r.d], (r.err > 0) ? 1 : 0);
                if (r.err > 0) chk("fail_vec", fv_w[r.d], r.first);
`endif
                pend     = 1'b1;
                pend_d   = r.d;
                pend_err = r.err;
                void'(exp_q.pop_front());
            end else if (done_w[r.d]) begin
                chk("done_early", 1, 0);
            end
        end else if (done_w[0] || done_w[1]) begin
            chk("spurious_done", 1, 0);
        end
    end

    task automatic start_only(input int d, input int fm);
        fault[d] = fm;
        @(posedge clk); #1 start_w[d] = 1'b1;
        @(posedge clk);
        exp_q.push_back(make_run(d, cyc, fm));
        #1 start_w[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int lim;
        bit ok;
        lim = (p_s(d) + 2) * p_nv(d) + 10;
        ok  = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk); #1;
            if (!busy_w[d]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("run_timeout", 0, 1);
    endtask

    task automatic run(input int d, input int fm, input int stray);
        int j;
        start_only(d, fm);
        if (stray == 1) begin
            @(posedge clk); #1 start_w[d] = 1'b1;
            repeat (2) @(posedge clk);
            #1 start_w[d] = 1'b0;
        end else if (stray == 2) begin
            j = $urandom_range(1, (p_s(d) + 2) * p_nv(d) - 1);
            repeat (j) @(posedge clk);
            #1 start_w[d] = 1'b1;
            @(posedge clk); #1 start_w[d] = 1'b0;
        end
        wait_idle(d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        for (int d = 0; d < 2; d++) begin
            start_w[d] = 1'b0;
            fault[d]   = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", busy_w[d], 0);
            chk("rst_done", done_w[d], 0);
            chk("rst_pass", pass_w[d], 0);
            chk("rst_err", err_w[d], 0);
            chk("rst_ops", {cin_w[d], in2_w[d], in1_w[d]}, 0);
        end
        rst = 1'b0;

        run(0, 0, 1);
        run(0, 1, 0);
        run(0, 2, 2);
        for (int i = 0; i < 4; i++) run(0, $urandom_range(0, 2), 2);

        // Reset in the middle of a run, just after vector 5 is loaded.
        start_only(0, 1);
        repeat (16) @(posedge clk);
        #1;
        chk("vec5_loaded", {cin_w[0], in2_w[0], in1_w[0]}, 5);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        chk("midrst_busy", busy_w[0], 0);
        chk("midrst_done", done_w[0], 0);
        chk("midrst_pass", pass_w[0], 0);
        chk("midrst_err", err_w[0], 0);
        chk("midrst_ops", {cin_w[0], in2_w[0], in1_w[0]}, 0);
`ifdef ADDER_CHK_FIRSTFAIL_EN
        chk("midrst_fval", fval_w[0], 0);
        chk("midrst_fvec", fv_w[0], 0);
`endif
        rst = 1'b0;
        run(0, 0, 0);

        // Start held high across done: a second run begins right after IDLE is re-entered.
        fault[0] = $urandom_range(0, 2);
        @(posedge clk); #1 start_w[0] = 1'b1;
        @(posedge clk);
        exp_q.push_back(make_run(0, cyc, fault[0]));
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (done_w[0]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("b2b_done_timeout", 0, 1);
        @(posedge clk);
        @(posedge clk);
        exp_q.push_back(make_run(0, cyc, fault[0]));
        #1 start_w[0] = 1'b0;
        wait_idle(0);

        run(1, 1, 0);
        run(1, 2, 2);

        repeat (4) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
